// File: rtl/axi_slice_dc_pwr_pkg.sv
// Shared types and default constants for the dual-clock AXI slice power controller.
package axi_slice_dc_pwr_pkg;

  localparam int unsigned DEF_MAX_OUTSTANDING = 16;
  localparam int unsigned DEF_WAKE_CYCLES     = 4;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_GATED,
    ST_WAKE,
    ST_ISOL
  } pwr_state_e;

endpackage

// File: rtl/axi_slice_dc_outstanding_cnt.sv
// Saturating outstanding-transaction counter; flags over/underflow attempts for one cycle.
module axi_slice_dc_outstanding_cnt #(
  parameter int unsigned MAX = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [$clog2(MAX+1)-1:0]   count_o,
  output logic                       ovf_o,
  output logic                       udf_o
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] count_q, count_d;

  // Simultaneous inc/dec cancels, so it never trips an error even at a limit.
  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    udf_o   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == CW'(MAX)) ovf_o   = 1'b1;
      else                     count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) udf_o   = 1'b1;
      else               count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/axi_slice_dc_pwr_ctrl.sv
// Power/isolation controller for the master side of a dual-clock AXI slice.
module axi_slice_dc_pwr_ctrl
  import axi_slice_dc_pwr_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned WAKE_CYCLES     = DEF_WAKE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sleep_req_i,
  input  logic isolate_req_i,
  input  logic incoming_req_i,
  input  logic aw_valid_i,
  input  logic aw_ready_i,
  input  logic ar_valid_i,
  input  logic ar_ready_i,
  input  logic w_valid_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i,
  output logic clock_down_o,
  output logic isolate_o,
  output logic clk_en_o,
  output logic sleep_ack_o,
  output logic isolate_ack_o,
  output logic busy_o,
  output logic err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          wr_ovf, wr_udf, rd_ovf, rd_udf;
  logic          cnt_idle;

  axi_slice_dc_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (aw_valid_i & aw_ready_i),
    .dec_i   (b_valid_i & b_ready_i),
    .count_o (wr_cnt),
    .ovf_o   (wr_ovf),
    .udf_o   (wr_udf)
  );

  axi_slice_dc_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (ar_valid_i & ar_ready_i),
    .dec_i   (r_valid_i & r_ready_i & r_last_i),
    .count_o (rd_cnt),
    .ovf_o   (rd_ovf),
    .udf_o   (rd_udf)
  );

  assign cnt_idle = (wr_cnt == '0) && (rd_cnt == '0);

  pwr_state_e    state_q, state_d;
  logic [WW-1:0] wake_q, wake_d;
  logic          clock_down_q, isolate_q, clk_en_q, sleep_ack_q, err_q;

  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    unique case (state_q)
      ST_RUN: begin
        if (isolate_req_i)    state_d = ST_ISOL;
        else if (sleep_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (isolate_req_i)     state_d = ST_ISOL;
        else if (!sleep_req_i) state_d = ST_RUN;
        else if (cnt_idle && !incoming_req_i && !w_valid_i) state_d = ST_GATED;
      end
      ST_GATED: begin
        if (incoming_req_i || !sleep_req_i || isolate_req_i) begin
          state_d = ST_WAKE;
          wake_d  = WW'(WAKE_CYCLES - 1);
        end
      end
      ST_WAKE: begin
        if (wake_q == '0) state_d = ST_RUN;
        else              wake_d  = wake_q - WW'(1);
      end
      ST_ISOL: begin
        if (!isolate_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      wake_q       <= '0;
      clock_down_q <= 1'b0;
      isolate_q    <= 1'b0;
      clk_en_q     <= 1'b1;
      sleep_ack_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_q       <= wake_d;
      clock_down_q <= (state_d == ST_GATED) || (state_d == ST_WAKE);
      isolate_q    <= (state_d == ST_ISOL);
      clk_en_q     <= (state_d != ST_GATED);
      sleep_ack_q  <= (state_d == ST_GATED);
      err_q        <= err_q | wr_ovf | wr_udf | rd_ovf | rd_udf;
    end
  end

  assign clock_down_o  = clock_down_q;
  assign isolate_o     = isolate_q;
  assign clk_en_o      = clk_en_q;
  assign sleep_ack_o   = sleep_ack_q;
  assign isolate_ack_o = isolate_q & cnt_idle;
  assign busy_o        = !cnt_idle;
  assign err_o         = err_q;

endmodule

// File: tb/tb_axi_slice_dc_pwr_ctrl.sv
// Scoreboard bench for axi_slice_dc_pwr_ctrl: a cycle model queues expected outputs per clock.
module tb_axi_slice_dc_pwr_ctrl;
  import axi_slice_dc_pwr_pkg::*;

  localparam int unsigned MAXO = 16;
  localparam int unsigned WAKE = 4;
  localparam int unsigned CW   = 5;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic sleep_req_i, isolate_req_i, incoming_req_i;
  logic aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i, w_valid_i;
  logic b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic clock_down_o, isolate_o, clk_en_o, sleep_ack_o, isolate_ack_o, busy_o, err_o;

  always #5 clk_i = ~clk_i;

  axi_slice_dc_pwr_ctrl #(.MAX_OUTSTANDING(MAXO), .WAKE_CYCLES(WAKE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .sleep_req_i(sleep_req_i), .isolate_req_i(isolate_req_i), .incoming_req_i(incoming_req_i),
    .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i),
    .w_valid_i(w_valid_i), .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .clock_down_o(clock_down_o), .isolate_o(isolate_o), .clk_en_o(clk_en_o),
    .sleep_ack_o(sleep_ack_o), .isolate_ack_o(isolate_ack_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {
    logic          cd, iso, ce, sack, iack, busy, err;
    logic [CW-1:0] wr, rd;
  } exp_t;

  exp_t       sb_q[$];
  pwr_state_e m_state;
  int         m_wr, m_rd, m_wake;
  logic       m_err;
  int unsigned n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    incoming_req_i = 0; aw_valid_i = 0; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
    w_valid_i = 0; b_valid_i = 0; b_ready_i = 0; r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
  endtask

  task automatic model_reset();
    m_state = ST_RUN; m_wr = 0; m_rd = 0; m_wake = 0; m_err = 0;
    sb_q.delete();
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cd   = (m_state == ST_GATED) || (m_state == ST_WAKE);
    e.iso  = (m_state == ST_ISOL);
    e.ce   = (m_state != ST_GATED);
    e.sack = (m_state == ST_GATED);
    e.iack = (m_state == ST_ISOL) && (m_wr == 0) && (m_rd == 0);
    e.busy = (m_wr != 0) || (m_rd != 0);
    e.err  = m_err;
    e.wr   = CW'(m_wr);
    e.rd   = CW'(m_rd);
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".clock_down"}, clock_down_o, 0);
    check_eq({tag, ".isolate"}, isolate_o, 0);
    check_eq({tag, ".clk_en"}, clk_en_o, 1);
    check_eq({tag, ".sleep_ack"}, sleep_ack_o, 0);
    check_eq({tag, ".isolate_ack"}, isolate_ack_o, 0);
    check_eq({tag, ".busy"}, busy_o, 0);
    check_eq({tag, ".err"}, err_o, 0);
    check_eq({tag, ".wr_cnt"}, dut.u_wr_cnt.count_o, 0);
    check_eq({tag, ".rd_cnt"}, dut.u_rd_cnt.count_o, 0);
  endtask

  // Advance the model with the currently driven inputs, clock the DUT, compare.
  task automatic cycle();
    exp_t       e;
    pwr_state_e ns;
    logic       wi, wd, ri, rdd;
    ns = m_state;
    case (m_state)
      ST_RUN:   if (isolate_req_i) ns = ST_ISOL; else if (sleep_req_i) ns = ST_DRAIN;
      ST_DRAIN: if (isolate_req_i) ns = ST_ISOL;
                else if (!sleep_req_i) ns = ST_RUN;
                else if (m_wr == 0 && m_rd == 0 && !incoming_req_i && !w_valid_i) ns = ST_GATED;
      ST_GATED: if (incoming_req_i || !sleep_req_i || isolate_req_i) begin
                  ns = ST_WAKE; m_wake = WAKE - 1;
                end
      ST_WAKE:  if (m_wake == 0) ns = ST_RUN; else m_wake--;
      ST_ISOL:  if (!isolate_req_i) ns = ST_RUN;
      default:  ns = ST_RUN;
    endcase
    m_state = ns;
    wi = aw_valid_i & aw_ready_i; wd = b_valid_i & b_ready_i;
    ri = ar_valid_i & ar_ready_i; rdd = r_valid_i & r_ready_i & r_last_i;
    if (wi && !wd) begin if (m_wr == MAXO) m_err = 1; else m_wr++; end
    else if (wd && !wi) begin if (m_wr == 0) m_err = 1; else m_wr--; end
    if (ri && !rdd) begin if (m_rd == MAXO) m_err = 1; else m_rd++; end
    else if (rdd && !ri) begin if (m_rd == 0) m_err = 1; else m_rd--; end
    sb_q.push_back(model_out());
    @(posedge clk_i); #1;
    e = sb_q.pop_front();
    check_eq("clock_down", clock_down_o, e.cd);
    check_eq("isolate", isolate_o, e.iso);
    check_eq("clk_en", clk_en_o, e.ce);
    check_eq("sleep_ack", sleep_ack_o, e.sack);
    check_eq("isolate_ack", isolate_ack_o, e.iack);
    check_eq("busy", busy_o, e.busy);
    check_eq("err", err_o, e.err);
    check_eq("wr_cnt", dut.u_wr_cnt.count_o, e.wr);
    check_eq("rd_cnt", dut.u_rd_cnt.count_o, e.rd);
  endtask

  task automatic apply_reset(input string tag);
    rst_ni = 0; clr(); sleep_req_i = 0; isolate_req_i = 0;
    #2;
    check_reset_values(tag);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  initial begin
    int n_wake;
    rst_ni = 1; clr(); sleep_req_i = 0; isolate_req_i = 0;
    model_reset();
    #1;
    apply_reset("reset0");
    repeat (2) cycle();

    // Idle sleep: DRAIN then GATED two cycles after the request.
    sleep_req_i = 1;
    cycle(); check_eq("sleep.drain_ack", sleep_ack_o, 0);
    cycle(); check_eq("sleep.gated_ack", sleep_ack_o, 1); check_eq("sleep.gated_clk_en", clk_en_o, 0);

    // Wake on incoming request: exactly WAKE cycles of clk_en with clock_down.
    incoming_req_i = 1; cycle(); incoming_req_i = 0; sleep_req_i = 0;
    n_wake = (clk_en_o && clock_down_o) ? 1 : 0;
    for (int i = 0; i < 10 && clk_en_o && clock_down_o; i++) begin
      cycle();
      if (clk_en_o && clock_down_o) n_wake++;
    end
    check_eq("wake.cycles", n_wake, WAKE);
    check_eq("wake.run_clock_down", clock_down_o, 0);

    // Drain waits for three outstanding writes.
    aw_valid_i = 1; aw_ready_i = 1; repeat (3) cycle(); clr();
    sleep_req_i = 1;
    repeat (3) cycle();
    check_eq("drain.busy", busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      b_valid_i = 1; b_ready_i = 1; cycle(); clr();
      check_eq("drain.not_gated", sleep_ack_o, 0);
      if (i < 2) cycle();
    end
    cycle(); check_eq("drain.gated_after_b", sleep_ack_o, 1);
    sleep_req_i = 0; repeat (6) cycle();
    check_eq("drain.back_run", clk_en_o, 1);

    // Isolation with two reads outstanding.
    ar_valid_i = 1; ar_ready_i = 1; repeat (2) cycle(); clr();
    isolate_req_i = 1; cycle();
    check_eq("isol.isolate", isolate_o, 1);
    check_eq("isol.ack_busy", isolate_ack_o, 0);
    r_valid_i = 1; r_ready_i = 1; cycle();
    r_last_i = 1; cycle(); check_eq("isol.ack_one_left", isolate_ack_o, 0);
    cycle(); clr(); check_eq("isol.ack_done", isolate_ack_o, 1);
    isolate_req_i = 0; cycle(); check_eq("isol.released", isolate_o, 0);

    // Simultaneous AR and r_last at count 5, then write underflow.
    ar_valid_i = 1; ar_ready_i = 1; repeat (5) cycle();
    r_valid_i = 1; r_ready_i = 1; r_last_i = 1; cycle(); clr();
    check_eq("same_cycle.rd_cnt", dut.u_rd_cnt.count_o, 5);
    r_valid_i = 1; r_ready_i = 1; r_last_i = 1; repeat (5) cycle(); clr();
    b_valid_i = 1; b_ready_i = 1; cycle(); clr();
    check_eq("udf.err", err_o, 1);
    repeat (5) cycle();
    check_eq("udf.err_sticky", err_o, 1);

    // Randomised mixed traffic and requests.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) sleep_req_i = ~sleep_req_i;
      if ($urandom_range(0, 31) == 0) isolate_req_i = ~isolate_req_i;
      incoming_req_i = ($urandom_range(0, 7) == 0);
      aw_valid_i = $urandom_range(0, 1); aw_ready_i = $urandom_range(0, 1);
      ar_valid_i = $urandom_range(0, 1); ar_ready_i = $urandom_range(0, 1);
      w_valid_i  = ($urandom_range(0, 3) == 0);
      b_valid_i  = $urandom_range(0, 1); b_ready_i = $urandom_range(0, 1);
      r_valid_i  = $urandom_range(0, 1); r_ready_i = $urandom_range(0, 1);
      r_last_i   = $urandom_range(0, 1);
      cycle();
    end

    // Write overflow, then asynchronous reset in the middle of DRAIN.
    apply_reset("reset1");
    aw_valid_i = 1; aw_ready_i = 1; repeat (17) cycle(); clr();
    check_eq("ovf.wr_cnt", dut.u_wr_cnt.count_o, 16);
    check_eq("ovf.err", err_o, 1);
    sleep_req_i = 1; repeat (2) cycle();
    check_eq("ovf.drain_busy", busy_o, 1);
    #2;
    rst_ni = 0;
    #1;
    check_reset_values("reset_mid_drain");
    model_reset(); clr(); sleep_req_i = 0;
    @(negedge clk_i); rst_ni = 1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
